// File: rtl/vec_ram_arb.sv
// ============================================================================
//  Module      : vec_ram_arb
//  Description : Two-requester round-robin arbiter/sequencer for the shared
//                vector RAM. Serves one single-beat read or write at a time
//                from port A or B and returns the read data (or a write
//                acknowledge) on the owning port's response channel.
//
//  Ports
//    clk_i, rst_ni                  clock, asynchronous active-low reset
//    {a,b}_req_valid_i / _ready_o   request handshake
//    {a,b}_req_addr_i               byte address (unaligned allowed)
//    {a,b}_req_wdata_i / _wstrb_i   write data / byte enables (0 = read)
//    {a,b}_rsp_valid_o / _ready_i   response handshake
//    {a,b}_rsp_rdata_o / _err_o     read data (0 for writes/errors), range error
//    ram_en_o, ram_we_o, ram_addr_o, ram_d_o   native RAM port (to vec_ram)
//    ram_d_i                        RAM read data, valid one cycle after enable
//
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

`ifndef BE_ADDR_W
`define BE_ADDR_W 24
`endif
`ifndef BE_DATA_W
`define BE_DATA_W 64
`endif
`ifndef BE_STRB_W
`define BE_STRB_W 8
`endif

module vec_ram_arb #(
    parameter logic [`BE_ADDR_W-1:0] MAX_ADDR = 24'hFFFFF8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  a_req_valid_i,
    output logic                  a_req_ready_o,
    input  logic [`BE_ADDR_W-1:0] a_req_addr_i,
    input  logic [`BE_DATA_W-1:0] a_req_wdata_i,
    input  logic [`BE_STRB_W-1:0] a_req_wstrb_i,
    output logic                  a_rsp_valid_o,
    input  logic                  a_rsp_ready_i,
    output logic [`BE_DATA_W-1:0] a_rsp_rdata_o,
    output logic                  a_rsp_err_o,

    input  logic                  b_req_valid_i,
    output logic                  b_req_ready_o,
    input  logic [`BE_ADDR_W-1:0] b_req_addr_i,
    input  logic [`BE_DATA_W-1:0] b_req_wdata_i,
    input  logic [`BE_STRB_W-1:0] b_req_wstrb_i,
    output logic                  b_rsp_valid_o,
    input  logic                  b_rsp_ready_i,
    output logic [`BE_DATA_W-1:0] b_rsp_rdata_o,
    output logic                  b_rsp_err_o,

    output logic                  ram_en_o,
    output logic [`BE_STRB_W-1:0] ram_we_o,
    output logic [`BE_ADDR_W-1:0] ram_addr_o,
    output logic [`BE_DATA_W-1:0] ram_d_o,
    input  logic [`BE_DATA_W-1:0] ram_d_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;

    logic                  r_prio_b;    // 1: B wins a tie (A was granted last)
    logic                  r_owner_b;   // owner of the access in flight
    logic                  r_is_write;
    logic                  r_err;
    logic [`BE_DATA_W-1:0] r_rdata;

    logic                  w_gnt_a;
    logic                  w_gnt_b;
    logic                  w_accept;
    logic                  w_in_range;
    logic                  w_rsp_hs;
    logic [`BE_ADDR_W-1:0] w_sel_addr;
    logic [`BE_DATA_W-1:0] w_sel_wdata;
    logic [`BE_STRB_W-1:0] w_sel_wstrb;

    // ------------------------------------------------------------------------
    // Arbitration and winner select
    // ------------------------------------------------------------------------
    always_comb begin
        w_gnt_a     = a_req_valid_i & (~b_req_valid_i | ~r_prio_b);
        w_gnt_b     = b_req_valid_i & (~a_req_valid_i |  r_prio_b);
        // Reset gates the accept so ready/enable fall to 0 the moment
        // rst_ni asserts, even while a request is held valid.
        w_accept    = rst_ni & (r_state == S_IDLE) & (w_gnt_a | w_gnt_b);
        w_sel_addr  = w_gnt_b ? b_req_addr_i  : a_req_addr_i;
        w_sel_wdata = w_gnt_b ? b_req_wdata_i : a_req_wdata_i;
        w_sel_wstrb = w_gnt_b ? b_req_wstrb_i : a_req_wstrb_i;
        w_in_range  = (w_sel_addr <= MAX_ADDR);
        w_rsp_hs    = (r_state == S_RESP) & (r_owner_b ? b_rsp_ready_i : a_rsp_ready_i);
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_DATA;
            S_DATA:  w_state_nxt = S_RESP;
            S_RESP:  if (w_rsp_hs) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        a_req_ready_o = 1'b0;
        b_req_ready_o = 1'b0;
        a_rsp_valid_o = 1'b0;
        b_rsp_valid_o = 1'b0;
        a_rsp_rdata_o = '0;
        b_rsp_rdata_o = '0;
        a_rsp_err_o   = 1'b0;
        b_rsp_err_o   = 1'b0;
        ram_en_o      = 1'b0;
        ram_we_o      = '0;
        ram_addr_o    = '0;
        ram_d_o       = '0;
        case (r_state)
            S_IDLE: begin
                a_req_ready_o = w_accept & w_gnt_a;
                b_req_ready_o = w_accept & w_gnt_b;
                // Out-of-range requests are acknowledged but never reach the RAM.
                if (w_accept && w_in_range) begin
                    ram_en_o   = 1'b1;
                    ram_we_o   = w_sel_wstrb;
                    ram_addr_o = w_sel_addr;
                    ram_d_o    = w_sel_wdata;
                end
            end
            S_RESP: begin
                if (r_owner_b) begin
                    b_rsp_valid_o = 1'b1;
                    b_rsp_rdata_o = r_rdata;
                    b_rsp_err_o   = r_err;
                end else begin
                    a_rsp_valid_o = 1'b1;
                    a_rsp_rdata_o = r_rdata;
                    a_rsp_err_o   = r_err;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Access bookkeeping and response capture
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_prio_b   <= 1'b0;
            r_owner_b  <= 1'b0;
            r_is_write <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
        end else if (w_accept) begin
            r_prio_b   <= w_gnt_a;
            r_owner_b  <= w_gnt_b;
            r_is_write <= |w_sel_wstrb;
            r_err      <= ~w_in_range;
            r_rdata    <= '0;
        end else if (r_state == S_DATA) begin
            // ram_d_i carries the read launched at the accept edge; anything
            // else on it is not ours and must not leak into the response.
            r_rdata <= (~r_is_write & ~r_err) ? ram_d_i : '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vec_ram_arb.sv
// ============================================================================
//  Module      : tb_vec_ram_arb
//  Description : Self-checking bench for vec_ram_arb. A byte-level RAM model
//                answers the native port; a separate reference byte memory,
//                updated from accepted requests, predicts every response.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

`ifndef BE_ADDR_W
`define BE_ADDR_W 24
`endif
`ifndef BE_DATA_W
`define BE_DATA_W 64
`endif
`ifndef BE_STRB_W
`define BE_STRB_W 8
`endif

module tb_vec_ram_arb;

    localparam int AW = `BE_ADDR_W;
    localparam int DW = `BE_DATA_W;
    localparam int SW = `BE_STRB_W;
    localparam logic [AW-1:0] C_MAX_ADDR = 24'hFFFFF8;

    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic [SW-1:0] strb; } req_t;
    typedef struct { logic [DW-1:0] rdata; logic err; } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_ni;

    logic          drv_valid [2];
    logic [AW-1:0] drv_addr  [2];
    logic [DW-1:0] drv_wdata [2];
    logic [SW-1:0] drv_wstrb [2];
    logic          drv_rsp_ready [2];

    logic a_req_ready_o, b_req_ready_o, a_rsp_valid_o, b_rsp_valid_o;
    logic a_rsp_err_o, b_rsp_err_o, ram_en_o;
    logic [DW-1:0] a_rsp_rdata_o, b_rsp_rdata_o, ram_d_o, ram_d_i;
    logic [SW-1:0] ram_we_o;
    logic [AW-1:0] ram_addr_o;

    vec_ram_arb #(.MAX_ADDR(C_MAX_ADDR)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .a_req_valid_i(drv_valid[0]), .a_req_ready_o(a_req_ready_o),
        .a_req_addr_i(drv_addr[0]), .a_req_wdata_i(drv_wdata[0]), .a_req_wstrb_i(drv_wstrb[0]),
        .a_rsp_valid_o(a_rsp_valid_o), .a_rsp_ready_i(drv_rsp_ready[0]),
        .a_rsp_rdata_o(a_rsp_rdata_o), .a_rsp_err_o(a_rsp_err_o),
        .b_req_valid_i(drv_valid[1]), .b_req_ready_o(b_req_ready_o),
        .b_req_addr_i(drv_addr[1]), .b_req_wdata_i(drv_wdata[1]), .b_req_wstrb_i(drv_wstrb[1]),
        .b_rsp_valid_o(b_rsp_valid_o), .b_rsp_ready_i(drv_rsp_ready[1]),
        .b_rsp_rdata_o(b_rsp_rdata_o), .b_rsp_err_o(b_rsp_err_o),
        .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_d_o(ram_d_o), .ram_d_i(ram_d_i)
    );

    int n_checks = 0;
    int n_pass   = 0;

    req_t req_q [2][$];
    rsp_t exp_q [2][$];
    logic acc  [2];
    logic hold [2];
    logic rand_rsp;
    logic [DW-1:0] last_rdata [2];

    // reference model of the arbiter as a whole
    logic busy;
    int   own;
    int   age;
    logic prio_b;

    logic [7:0] ram_mem [int];
    logic [7:0] ref_mem [int];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        for (int i = 0; i < SW; i++)
            v[8*i +: 8] = ref_mem.exists(int'(a) + i) ? ref_mem[int'(a) + i] : 8'h00;
        return v;
    endfunction

    function automatic logic [DW-1:0] ram_read(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        for (int i = 0; i < SW; i++)
            v[8*i +: 8] = ram_mem.exists(int'(a) + i) ? ram_mem[int'(a) + i] : 8'h00;
        return v;
    endfunction

    function automatic req_t mk(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        req_t r;
        r.addr = a; r.data = d; r.strb = s;
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        logic [AW-1:0] top [5];
        top = '{24'hFFFFF0, 24'hFFFFF8, 24'hFFFFF9, 24'hFFFFFC, 24'hFFFFFF};
        if ($urandom_range(0, 7) == 0) r.addr = top[$urandom_range(0, 4)];
        else                           r.addr = AW'($urandom_range(0, 40));
        r.data = {$urandom, $urandom};
        r.strb = ($urandom_range(0, 1) == 0) ? '0 : SW'($urandom);
        return r;
    endfunction

    // ---------------- RAM environment model (one-cycle read latency) --------
    initial begin
        ram_d_i = '0;
        forever begin
            @(posedge clk);
            if (ram_en_o && ram_we_o == '0) begin
                ram_d_i <= ram_read(ram_addr_o);
            end else begin
                if (ram_en_o)
                    for (int i = 0; i < SW; i++)
                        if (ram_we_o[i]) ram_mem[int'(ram_addr_o) + i] = ram_d_o[8*i +: 8];
                ram_d_i <= {$urandom, $urandom};
            end
        end
    end

    // ---------------- request / response-ready driver -----------------------
    initial begin
        req_t r;
        forever begin
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (acc[p]) begin
                    acc[p]       = 1'b0;
                    drv_valid[p] = 1'b0;
                    drv_addr[p]  = AW'($urandom);
                    drv_wdata[p] = {$urandom, $urandom};
                    drv_wstrb[p] = SW'($urandom);
                end
                if (!drv_valid[p] && req_q[p].size() > 0 && rst_ni) begin
                    r = req_q[p].pop_front();
                    drv_valid[p] = 1'b1;
                    drv_addr[p]  = r.addr;
                    drv_wdata[p] = r.data;
                    drv_wstrb[p] = r.strb;
                end
                drv_rsp_ready[p] = hold[p] ? 1'b0 : (rand_rsp ? ($urandom_range(0, 3) != 0) : 1'b1);
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------------------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                busy = 1'b0; prio_b = 1'b0; age = 0;
                exp_q[0].delete(); exp_q[1].delete();
            end else begin
                logic done;
                int   win;
                done = 1'b0;
                if (busy) age++;
                for (int p = 0; p < 2; p++) begin
                    logic          v, ev;
                    logic [DW-1:0] rd;
                    logic          er;
                    v  = (p == 0) ? a_rsp_valid_o : b_rsp_valid_o;
                    rd = (p == 0) ? a_rsp_rdata_o : b_rsp_rdata_o;
                    er = (p == 0) ? a_rsp_err_o   : b_rsp_err_o;
                    ev = busy && own == p && age >= 2;
                    chk((p == 0) ? "a_rsp_valid" : "b_rsp_valid", 64'(v), 64'(ev));
                    if (v && ev && exp_q[p].size() > 0) begin
                        chk((p == 0) ? "a_rsp_rdata" : "b_rsp_rdata", rd, exp_q[p][0].rdata);
                        chk((p == 0) ? "a_rsp_err" : "b_rsp_err", 64'(er), 64'(exp_q[p][0].err));
                        if (drv_rsp_ready[p]) begin
                            last_rdata[p] = rd;
                            void'(exp_q[p].pop_front());
                            done = 1'b1;
                        end
                    end
                end
                // Expected grant: only when idle; a lone requester wins, a tie
                // goes to the port not granted most recently.
                win = -1;
                if (!busy) begin
                    if (drv_valid[0] && drv_valid[1]) win = prio_b ? 1 : 0;
                    else if (drv_valid[0])            win = 0;
                    else if (drv_valid[1])            win = 1;
                end
                chk("req_ready", 64'({b_req_ready_o, a_req_ready_o}),
                    64'((win == 1) ? 2'b10 : (win == 0) ? 2'b01 : 2'b00));
                if (win >= 0) begin
                    logic inr;
                    rsp_t e;
                    inr = drv_addr[win] <= C_MAX_ADDR;
                    chk("ram_en", 64'(ram_en_o), 64'(inr));
                    chk("ram_we", 64'(ram_we_o), 64'(inr ? drv_wstrb[win] : '0));
                    if (inr) begin
                        chk("ram_addr", 64'(ram_addr_o), 64'(drv_addr[win]));
                        chk("ram_d", ram_d_o, drv_wdata[win]);
                    end
                    e.err   = !inr;
                    e.rdata = (inr && drv_wstrb[win] == '0) ? ref_read(drv_addr[win]) : '0;
                    if (inr)
                        for (int i = 0; i < SW; i++)
                            if (drv_wstrb[win][i]) ref_mem[int'(drv_addr[win]) + i] = drv_wdata[win][8*i +: 8];
                    exp_q[win].push_back(e);
                    busy = 1'b1; own = win; age = 0; acc[win] = 1'b1;
                    prio_b = (win == 0);
                end else begin
                    chk("ram_en_off", 64'(ram_en_o), 64'(0));
                end
                if (done) busy = 1'b0;
            end
        end
    end

    // ---------------- helpers ------------------------------------------------
    task automatic chk_zero(input string tag);
        chk({tag, "_a_ready"}, 64'(a_req_ready_o), 0);
        chk({tag, "_b_ready"}, 64'(b_req_ready_o), 0);
        chk({tag, "_a_valid"}, 64'(a_rsp_valid_o), 0);
        chk({tag, "_b_valid"}, 64'(b_rsp_valid_o), 0);
        chk({tag, "_a_err"},   64'(a_rsp_err_o), 0);
        chk({tag, "_b_err"},   64'(b_rsp_err_o), 0);
        chk({tag, "_a_rdata"}, a_rsp_rdata_o, 0);
        chk({tag, "_b_rdata"}, b_rsp_rdata_o, 0);
        chk({tag, "_ram_en"},  64'(ram_en_o), 0);
        chk({tag, "_ram_we"},  64'(ram_we_o), 0);
        chk({tag, "_ram_addr"}, 64'(ram_addr_o), 0);
        chk({tag, "_ram_d"},   ram_d_o, 0);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((req_q[0].size() > 0 || req_q[1].size() > 0 || drv_valid[0] || drv_valid[1] || busy)
               && n < budget) begin
            @(negedge clk); #2;
            n++;
        end
        if (n >= budget) begin
            n_checks++;
            $display("FAIL wait_idle: timeout after %0d cycles, busy=%0b", budget, busy);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------------------------------------
    initial begin
        rst_ni = 1'b0; rand_rsp = 1'b0; busy = 1'b0; own = 0; age = 0; prio_b = 1'b0;
        for (int p = 0; p < 2; p++) begin
            acc[p] = 1'b0; hold[p] = 1'b0; drv_rsp_ready[p] = 1'b1; last_rdata[p] = '0;
            drv_valid[p] = 1'b1; drv_addr[p] = '0; drv_wdata[p] = '1; drv_wstrb[p] = '1;
        end
        // reset with both requests valid: nothing may be granted
        repeat (3) @(negedge clk);
        chk_zero("reset");
        drv_valid[0] = 1'b0; drv_valid[1] = 1'b0;
        @(posedge clk); #2; rst_ni = 1'b1;
        @(negedge clk); #2;

        // single write, then unaligned read spanning two words
        req_q[0].push_back(mk(24'h000000, 64'h1122334455667788, 8'hFF));
        wait_idle(100);
        req_q[0].push_back(mk(24'h000008, 64'h2233445566778899, 8'hFF));
        req_q[0].push_back(mk(24'h000002, 64'h0, 8'h00));
        wait_idle(100);
        chk("unaligned_read", last_rdata[0], 64'h8899112233445566);

        // simultaneous requests alternate
        for (int k = 0; k < 3; k++) begin
            req_q[0].push_back(mk(AW'(16 + k), 64'h0, 8'h00));
            req_q[1].push_back(mk(AW'(24 + k), 64'h0, 8'h00));
        end
        wait_idle(200);

        // out-of-range read, then normal service
        req_q[1].push_back(mk(24'hFFFFFC, 64'h0, 8'h00));
        req_q[1].push_back(mk(24'h000000, 64'h0, 8'h00));
        wait_idle(100);

        // response back-pressure with B waiting
        hold[0] = 1'b1;
        req_q[0].push_back(mk(24'h000003, 64'h0, 8'h00));
        req_q[1].push_back(mk(24'h000008, 64'h0, 8'h00));
        repeat (8) @(negedge clk);
        #2; hold[0] = 1'b0;
        wait_idle(100);

        // reset during DATA of an A read
        req_q[0].push_back(mk(24'h000008, 64'h0, 8'h00));
        begin
            int n;
            n = 0;
            do begin @(negedge clk); #2; n++; end while (!a_req_ready_o && n < 50);
            if (n >= 50) begin n_checks++; $display("FAIL reset_accept: A never granted"); end
        end
        @(posedge clk); #2;
        rst_ni = 1'b0;
        #1 chk_zero("midrst");
        repeat (2) @(posedge clk);
        #2 rst_ni = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        req_q[0].push_back(mk(24'h000010, 64'h0, 8'h00));
        req_q[1].push_back(mk(24'h000018, 64'h0, 8'h00));
        wait_idle(100);
        req_q[1].push_back(mk(24'h000020, 64'h0, 8'h00));
        wait_idle(100);

        // randomized traffic with random response back-pressure
        rand_rsp = 1'b1;
        for (int i = 0; i < 600; i++) begin
            for (int p = 0; p < 2; p++)
                if (req_q[p].size() < 2 && $urandom_range(0, 2) == 0)
                    req_q[p].push_back(rand_req());
            @(negedge clk); #2;
        end
        wait_idle(5000);
        rand_rsp = 1'b0;
        repeat (3) @(negedge clk);

        chk("a_exp_q_empty", 64'(exp_q[0].size()), 0);
        chk("b_exp_q_empty", 64'(exp_q[1].size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vec_ram_arb.md
Name: vec_ram_arb

Overview:
Two-requester round-robin arbiter and sequencer for the shared vector RAM (vec_ram). Accepts single-beat read/write requests from ports A and B over valid/ready handshakes. Drives the RAM native port for one access at a time and returns the read data or write acknowledge to the owning requester. Sits between the vector datapath masters and vec_ram; widths come from constants.vh (`BE_ADDR_W=24, `BE_DATA_W=64, `BE_STRB_W=8).

Parameters:
MAX_ADDR, 24'hFFFFF8, highest legal byte start address; requests above it are rejected with error and never reach the RAM.

Ports:
clk_i  in  1  clock; all logic on rising edge.
rst_ni  in  1  asynchronous, active-low reset.
a_req_valid_i / b_req_valid_i  in  1  request valid, port A / B.
a_req_ready_o / b_req_ready_o  out  1  request accepted this cycle.
a_req_addr_i / b_req_addr_i  in  `BE_ADDR_W  byte address; unaligned allowed.
a_req_wdata_i / b_req_wdata_i  in  `BE_DATA_W  write data.
a_req_wstrb_i / b_req_wstrb_i  in  `BE_STRB_W  byte enables; all-zero means read.
a_rsp_valid_o / b_rsp_valid_o  out  1  response valid.
a_rsp_ready_i / b_rsp_ready_i  in  1  response accepted.
a_rsp_rdata_o / b_rsp_rdata_o  out  `BE_DATA_W  read data; 0 for writes and errors.
a_rsp_err_o / b_rsp_err_o  out  1  address out of range.
ram_en_o  out  1  to vec_ram en_i.
ram_we_o  out  `BE_STRB_W  to vec_ram we_i.
ram_addr_o  out  `BE_ADDR_W  to vec_ram addr_i.
ram_d_o  out  `BE_DATA_W  to vec_ram d_i.
ram_d_i  in  `BE_DATA_W  from vec_ram d_o; valid one cycle after a read enable.

Behaviour:
- Reset (async assert, sync release): state=IDLE; all *_ready_o, *_rsp_valid_o, *_err_o, ram_en_o = 0; ram_we_o, ram_addr_o, ram_d_o, rsp_rdata = 0; RR pointer favours A.
- FSM states: IDLE, DATA, RESP.
- IDLE: if no valid, stay; all RAM outputs 0.
  - If exactly one valid, it wins. If both, the port not granted most recently wins; after reset A wins.
  - Winner's req_ready_o=1 combinationally in the same cycle, and only in IDLE. Loser's ready stays 0 and it holds its request.
  - In-range grant (addr <= MAX_ADDR): ram_en_o=1, ram_addr_o/ram_we_o/ram_d_o driven combinationally from the winner's inputs, so the RAM samples at that edge.
  - Out-of-range grant: ram_en_o=0, ram_we_o=0.
  - Register owner, is_write (|wstrb) and err. RR pointer updates to the winner. Go to DATA.
- DATA (1 cycle): ram_en_o=0.
  - Capture rsp_rdata = ram_d_i if in-range read, else 0. Capture err.
  - Go to RESP.
- RESP: owner's rsp_valid_o=1 with rdata/err held stable until rsp_ready_i=1. Non-owner rsp_valid_o=0.
  - On handshake, clear rsp_valid the next cycle and go to IDLE.
  - No new grant occurs in the handshake cycle.
- Latency: accept at edge T; rsp_valid_o high from T+2. Minimum 3 cycles per access; rsp_ready held high gives exactly one access every 3 cycles.
- Requests are not reordered or dropped. Data passes through unmodified; byte lane/unaligned handling belongs to vec_ram.
- Request inputs are sampled only in the accept cycle and may change afterwards.
- Reset mid-access: the in-flight response is discarded with no rsp_valid. A RAM write already sampled stays committed.

Test Plan:
- A writes addr 0x000000, data 0x1122334455667788, strb 0xFF; B idle -> a_req_ready_o=1 same cycle; ram_en_o=1, ram_we_o=0xFF; a_rsp_valid_o two edges later, rdata=0, err=0.
- A writes 0x2233445566778899 at 0x000008; then A reads 0x000002, strb 0 -> a_rsp_rdata_o=0x8899112233445566.
- A and B valid together from reset, both reads -> A granted first and B on the next IDLE; repeat both valid -> B then A, alternating; b_rsp_valid_o never asserted for A's access.
- B reads addr 0xFFFFFC with MAX_ADDR=0xFFFFF8 -> ram_en_o stays 0; b_rsp_err_o=1, rdata=0; the next in-range request is served normally.
- A read accepted, a_rsp_ready_i held low 5 cycles -> a_rsp_valid_o and rdata stable; B request waits with b_req_ready_o=0; B is granted in the IDLE cycle after A's handshake.
- rst_ni pulsed low during DATA -> all outputs 0 immediately; no response after release; next request from B is granted over a simultaneous A only if A is absent (pointer favours A).
